// File: rtl/ea_calc.sv
// KV10 effective-address calculator: resolves E from an instruction word,
// applying AC indexing and following indirect words until a direct address is found.
module ea_calc #(
   parameter int INT_BREAK = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [0:35]  inst,
   output logic         busy,
   output logic         done,
   output logic [18:35] e,
   output logic [0:8]   op,
   output logic [0:3]   ac,
   output logic [0:3]   ac_raddr,
   input  logic [0:35]  ac_rdata,
   output logic         mem_read,
   output logic [18:35] mem_addr,
   input  logic         mem_ack,
   input  logic [0:35]  mem_rdata,
   input  logic         mem_fault,
   input  logic         intr_pending,
   output logic         aborted,
   output logic         fault
);

   typedef enum logic [2:0] {IDLE, EVAL, INDEX, IND_REQ, FINISH} state_t;

   state_t        state;
   logic          ind;
   logic [0:3]    idx;
   logic [18:35]  y;
   logic [18:35]  eff;
   logic          at_check;
   logic          unused_bits;

   // Only the right half of an AC takes part in address arithmetic; the
   // instruction part of an indirect word is irrelevant to the chain.
   assign unused_bits = ^{ac_rdata[0:17], mem_rdata[0:12]};

   // The candidate address for this level, and whether this cycle decides
   // between finishing, breaking the chain, or fetching the next indirect word.
   always_comb begin
      eff      = y;
      at_check = 1'b0;
      if (state == INDEX) begin
         eff      = y + ac_rdata[18:35];
         at_check = 1'b1;
      end else if (state == EVAL && idx == 4'd0) begin
         at_check = 1'b1;
      end
   end

   // ac_raddr is loaded together with X so the register file already has the
   // index address during EVAL and returns the AC in time for INDEX.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         aborted  <= 1'b0;
         fault    <= 1'b0;
         mem_read <= 1'b0;
         e        <= '0;
         op       <= '0;
         ac       <= '0;
         ac_raddr <= '0;
         mem_addr <= '0;
         ind      <= 1'b0;
         idx      <= '0;
         y        <= '0;
      end else begin
         done    <= 1'b0;
         aborted <= 1'b0;
         fault   <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op       <= inst[0:8];
                  ac       <= inst[9:12];
                  ind      <= inst[13];
                  idx      <= inst[14:17];
                  ac_raddr <= inst[14:17];
                  y        <= inst[18:35];
                  busy     <= 1'b1;
                  state    <= EVAL;
               end
            end
            EVAL: begin
               if (idx != 4'd0) state <= INDEX;
            end
            IND_REQ: begin
               if (mem_ack) begin
                  mem_read <= 1'b0;
                  if (mem_fault) begin
                     fault <= 1'b1;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     ind      <= mem_rdata[13];
                     idx      <= mem_rdata[14:17];
                     ac_raddr <= mem_rdata[14:17];
                     y        <= mem_rdata[18:35];
                     state    <= EVAL;
                  end
               end
            end
            FINISH: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // A pending interrupt is honoured only before a new indirect read.
         if (at_check) begin
            if (!ind) begin
               e     <= eff;
               done  <= 1'b1;
               state <= FINISH;
            end else if ((INT_BREAK != 0) && intr_pending) begin
               aborted <= 1'b1;
               busy    <= 1'b0;
               state   <= IDLE;
            end else begin
               mem_addr <= eff;
               mem_read <= 1'b1;
               state    <= IND_REQ;
            end
         end
      end
   end

endmodule
